bcd_to_bin_seq: RTL

Parametrised, multi-digit, sequential BCD-to-binary converter. Accepts a packed DIGITS-digit BCD word over a valid/ready handshake and converts it iteratively, one digit per clock, most-significant digit first, using acc = acc*10 + digit. Returns the binary result and an invalid-digit flag over a second valid/ready handshake. Replaces the single-byte combinational converter wherever operand width exceeds two digits or timing cannot absorb a wide multiply.

---
 rtl/bcd_to_bin_seq_if.sv | 24 ++
 rtl/bcd_to_bin_seq.sv | 84 ++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq_if.sv
// Handshake bundle for the sequential BCD-to-binary converter.
// The producer/consumer side uses the master modport; the converter uses slave.
interface bcd_to_bin_seq_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic                  out_valid;
  logic                  out_ready;
  logic [BIN_W-1:0]      bin;
  logic                  err;

  modport master (
    output in_valid, bcd, out_ready,
    input  in_ready, out_valid, bin, err
  );

  modport slave (
    input  in_valid, bcd, out_ready,
    output in_ready, out_valid, bin, err
  );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Iterative BCD-to-binary converter: one digit per clock, MSD first,
// acc = acc*10 + digit, with a sticky flag for nibbles above 9.
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_to_bin_seq_if.slave  io
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   acc_q, acc_d;
  logic [W-1:0]       sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [3:0]         top_nib;

  assign top_nib = sr_q[W-1 -: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Times ten is built from two shifts so no wide multiplier is needed.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          sr_d    = io.bcd;
          acc_d   = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        acc_d = (acc_q << 3) + (acc_q << 1) + BIN_W'(top_nib);
        sr_d  = sr_q << 4;
        cnt_d = cnt_q + 1'b1;
        err_d = err_q | (top_nib > 4'd9);
        if (cnt_q == CNT_W'(DIGITS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (io.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    io.in_ready  = (state_q == IDLE);
    io.out_valid = (state_q == DONE);
    io.bin       = acc_q;
    io.err       = err_q;
  end

endmodule
